// File: rtl/fft_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : fft_loader_if
// Description : Sample-stream and addctrl-side signals of the FFT input
//               framing stage. The slave modport is the loader's view; the
//               master modport is the view of the surrounding logic (sample
//               source, addctrl, status consumers).
// Revision    : 1.0 - initial release
// ============================================================================
interface fft_loader_if #(
    parameter int BIT_WIDTH = 16,
    parameter int N         = 9
);
    logic                   sample_valid;
    logic [BIT_WIDTH-1:0]   sample_in;
    logic                   fft_done;
    logic                   fft_load;
    logic [N-1:0]           add_rd;
    logic [2*BIT_WIDTH-1:0] wr_data;
    logic                   fft_start;
    logic                   busy;
    logic                   overrun;
    logic [7:0]             drop_cnt;

    modport master (
        output sample_valid,
        output sample_in,
        output fft_done,
        input  fft_load,
        input  add_rd,
        input  wr_data,
        input  fft_start,
        input  busy,
        input  overrun,
        input  drop_cnt
    );

    modport slave (
        input  sample_valid,
        input  sample_in,
        input  fft_done,
        output fft_load,
        output add_rd,
        output wr_data,
        output fft_start,
        output busy,
        output overrun,
        output drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fft_loader.sv
`default_nettype none
// ============================================================================
// Module      : fft_loader
// Description : Input framing stage ahead of addctrl. Writes 2^N samples into
//               RAM0 in natural order, pulses fft_start when the frame is
//               complete, then refuses input until fft_done. Refused samples
//               are reported with an overrun pulse and a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_loader #(
    parameter int BIT_WIDTH = 16,
    parameter int N         = 9,
    parameter int SIGNED_IN = 1
) (
    input  wire logic    clk,
    input  wire logic    reset,
    fft_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [N-1:0] c_last_addr = {N{1'b1}};
    localparam logic [7:0]   c_drop_max  = 8'hFF;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [N-1:0]           r_cnt;
    logic [N-1:0]           w_cnt_next;

    logic                   r_fft_load;
    logic                   w_fft_load_next;
    logic [N-1:0]           r_add_rd;
    logic [N-1:0]           w_add_rd_next;
    logic [2*BIT_WIDTH-1:0] r_wr_data;
    logic [2*BIT_WIDTH-1:0] w_wr_data_next;
    logic                   r_fft_start;
    logic                   w_fft_start_next;
    logic                   r_busy;
    logic                   w_busy_next;
    logic                   r_overrun;
    logic                   w_overrun_next;
    logic [7:0]             r_drop_cnt;
    logic [7:0]             w_drop_cnt_next;

    logic [BIT_WIDTH-1:0]   w_sample_conv;

    // Sample format: two's complement passes through, offset binary gets its MSB flipped
    generate
        if (SIGNED_IN != 0) begin : g_signed
            assign w_sample_conv = bus.sample_in;
        end else begin : g_offset
            assign w_sample_conv = {~bus.sample_in[BIT_WIDTH-1], bus.sample_in[BIT_WIDTH-2:0]};
        end
    endgenerate

    // Next-state and next-output decode; every output is registered one cycle later
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_fft_load_next  = 1'b0;
        w_add_rd_next    = r_add_rd;
        w_wr_data_next   = r_wr_data;
        w_fft_start_next = 1'b0;
        w_overrun_next   = 1'b0;
        w_drop_cnt_next  = r_drop_cnt;

        case (r_state)
            ST_LOAD: begin
                // fft_done is meaningless here and deliberately ignored
                if (bus.sample_valid) begin
                    w_fft_load_next = 1'b1;
                    w_add_rd_next   = r_cnt;
                    w_wr_data_next  = {w_sample_conv, {BIT_WIDTH{1'b0}}};
                    if (r_cnt == c_last_addr) begin
                        w_cnt_next   = '0;
                        w_state_next = ST_START;
                    end else begin
                        w_cnt_next   = r_cnt + N'(1);
                    end
                end
            end
            ST_START: begin
                w_fft_start_next = 1'b1;
                w_state_next     = ST_WAIT;
            end
            ST_WAIT: begin
                // A sample coinciding with fft_done is still dropped below
                if (bus.fft_done) begin
                    w_state_next = ST_LOAD;
                end
            end
            default: begin
                w_state_next = ST_LOAD;
                w_cnt_next   = '0;
            end
        endcase

        // Any strobe outside LOAD is discarded and accounted for
        if ((r_state != ST_LOAD) && bus.sample_valid) begin
            w_overrun_next = 1'b1;
            if (r_drop_cnt != c_drop_max) begin
                w_drop_cnt_next = r_drop_cnt + 8'd1;
            end
        end

        // busy tracks the state the FSM is entering so it lines up with START/WAIT
        w_busy_next = (w_state_next != ST_LOAD);
    end

    // State, frame counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_LOAD;
            r_cnt       <= '0;
            r_fft_load  <= 1'b0;
            r_add_rd    <= '0;
            r_wr_data   <= '0;
            r_fft_start <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_fft_load  <= w_fft_load_next;
            r_add_rd    <= w_add_rd_next;
            r_wr_data   <= w_wr_data_next;
            r_fft_start <= w_fft_start_next;
            r_busy      <= w_busy_next;
            r_overrun   <= w_overrun_next;
            r_drop_cnt  <= w_drop_cnt_next;
        end
    end

    assign bus.fft_load  = r_fft_load;
    assign bus.add_rd    = r_add_rd;
    assign bus.wr_data   = r_wr_data;
    assign bus.fft_start = r_fft_start;
    assign bus.busy      = r_busy;
    assign bus.overrun   = r_overrun;
    assign bus.drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fft_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_loader
// Description : Directed self-checking bench for fft_loader (two's complement
//               instance plus an offset-binary instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_loader;

    localparam int BW    = 16;
    localparam int NN    = 9;
    localparam int FRAME = 512;

    logic clk = 1'b0;
    logic reset;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    fft_loader_if #(.BIT_WIDTH(BW), .N(NN)) bus ();
    fft_loader_if #(.BIT_WIDTH(BW), .N(NN)) bus_ob ();

    fft_loader #(.BIT_WIDTH(BW), .N(NN), .SIGNED_IN(1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    fft_loader #(.BIT_WIDTH(BW), .N(NN), .SIGNED_IN(0)) u_dut_ob (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_ob.slave)
    );

    // One strobe on the main DUT; returns at the negedge after the sampling edge
    task automatic strobe(input logic [BW-1:0] value);
        @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.sample_in    = value;
        @(negedge clk);
        bus.sample_valid = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        bus.fft_done = 1'b1;
        @(negedge clk);
        bus.fft_done = 1'b0;
    endtask

    // Drives the remainder of a frame whose start was already checked
    task automatic finish_frame(input int first);
        for (int k = first; k < FRAME; k++) strobe(16'(k));
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (bus.fft_load !== 1'b0 || bus.add_rd !== 9'd0 || bus.wr_data !== 32'h0 ||
            bus.fft_start !== 1'b0 || bus.busy !== 1'b0 || bus.overrun !== 1'b0 ||
            bus.drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset: load=%b addr=%0d data=%h start=%b busy=%b ovr=%b drop=%0d, want all 0",
                     bus.fft_load, bus.add_rd, bus.wr_data, bus.fft_start, bus.busy, bus.overrun, bus.drop_cnt);
        end
        reset = 1'b0;
        // fft_done in LOAD must not disturb anything
        pulse_done();
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.fft_start !== 1'b0) begin
            errors++;
            $display("FAIL done_in_load: busy=%b start=%b, want 0 0", bus.busy, bus.fft_start);
        end
    endtask

    task automatic test_natural_frame();
        for (int k = 0; k < FRAME; k++) begin
            strobe(16'(k));
            vectors++;
            if (bus.fft_load !== 1'b1 || bus.add_rd !== 9'(k) || bus.wr_data !== {16'(k), 16'h0} ||
                bus.fft_start !== 1'b0 || bus.overrun !== 1'b0) begin
                errors++;
                $display("FAIL frame k=%0d: load=%b addr=%0d data=%h start=%b ovr=%b, want 1 %0d %h 0 0",
                         k, bus.fft_load, bus.add_rd, bus.wr_data, bus.fft_start, bus.overrun, k, {16'(k), 16'h0});
            end
        end
        @(negedge clk);
        vectors++;
        if (bus.fft_start !== 1'b1 || bus.busy !== 1'b1 || bus.fft_load !== 1'b0) begin
            errors++;
            $display("FAIL frame_start: start=%b busy=%b load=%b, want 1 1 0", bus.fft_start, bus.busy, bus.fft_load);
        end
        @(negedge clk);
        vectors++;
        if (bus.fft_start !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL start_width: start=%b busy=%b, want 0 1", bus.fft_start, bus.busy);
        end
    endtask

    task automatic test_drops();
        for (int i = 0; i < 3; i++) begin
            strobe(16'h1234);
            vectors++;
            if (bus.overrun !== 1'b1 || bus.fft_load !== 1'b0 || bus.drop_cnt !== 8'(i + 1)) begin
                errors++;
                $display("FAIL drop %0d: ovr=%b load=%b drop=%0d, want 1 0 %0d",
                         i, bus.overrun, bus.fft_load, bus.drop_cnt, i + 1);
            end
        end
        @(negedge clk);
        vectors++;
        if (bus.overrun !== 1'b0 || bus.drop_cnt !== 8'd3 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_idle: ovr=%b drop=%0d busy=%b, want 0 3 1", bus.overrun, bus.drop_cnt, bus.busy);
        end
        pulse_done();
        vectors++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL done_busy: busy=%b, want 0", bus.busy);
        end
        strobe(16'h0042);
        vectors++;
        if (bus.fft_load !== 1'b1 || bus.add_rd !== 9'd0 || bus.wr_data !== 32'h0042_0000) begin
            errors++;
            $display("FAIL reload: load=%b addr=%0d data=%h, want 1 0 00420000",
                     bus.fft_load, bus.add_rd, bus.wr_data);
        end
        finish_frame(1);
        pulse_done();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i <= FRAME; i++) begin
            @(negedge clk);
            if (i > 0) begin
                vectors++;
                if (bus.fft_load !== 1'b1 || bus.add_rd !== 9'(i - 1) ||
                    bus.wr_data !== {16'((i - 1) * 7), 16'h0} || bus.overrun !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b i=%0d: load=%b addr=%0d data=%h ovr=%b, want 1 %0d %h 0",
                             i - 1, bus.fft_load, bus.add_rd, bus.wr_data, bus.overrun,
                             i - 1, {16'((i - 1) * 7), 16'h0});
                end
            end
            if (i < FRAME) begin
                bus.sample_valid = 1'b1;
                bus.sample_in    = 16'(i * 7);
            end else begin
                bus.sample_valid = 1'b0;
            end
        end
        @(negedge clk);
        vectors++;
        if (bus.fft_start !== 1'b1 || bus.fft_load !== 1'b0 || bus.drop_cnt !== 8'd3) begin
            errors++;
            $display("FAIL b2b_start: start=%b load=%b drop=%0d, want 1 0 3",
                     bus.fft_start, bus.fft_load, bus.drop_cnt);
        end
    endtask

    task automatic test_done_collision_and_reset();
        @(negedge clk);
        bus.fft_done     = 1'b1;
        bus.sample_valid = 1'b1;
        bus.sample_in    = 16'h7777;
        @(negedge clk);
        bus.fft_done     = 1'b0;
        bus.sample_valid = 1'b0;
        vectors++;
        if (bus.overrun !== 1'b1 || bus.fft_load !== 1'b0 || bus.drop_cnt !== 8'd4 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL collision: ovr=%b load=%b drop=%0d busy=%b, want 1 0 4 0",
                     bus.overrun, bus.fft_load, bus.drop_cnt, bus.busy);
        end
        for (int k = 0; k < 100; k++) begin
            strobe(16'(16'h0100 + k));
            vectors++;
            if (bus.fft_load !== 1'b1 || bus.add_rd !== 9'(k) || bus.wr_data !== {16'(16'h0100 + k), 16'h0}) begin
                errors++;
                $display("FAIL post_collision k=%0d: load=%b addr=%0d data=%h, want 1 %0d",
                         k, bus.fft_load, bus.add_rd, bus.wr_data, k);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (bus.drop_cnt !== 8'd0 || bus.busy !== 1'b0 || bus.fft_load !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: drop=%0d busy=%b load=%b, want 0 0 0",
                     bus.drop_cnt, bus.busy, bus.fft_load);
        end
        for (int k = 0; k < FRAME; k++) begin
            strobe(16'(16'hA000 + k));
            vectors++;
            if (bus.fft_load !== 1'b1 || bus.add_rd !== 9'(k) || bus.fft_start !== 1'b0 ||
                bus.wr_data !== {16'(16'hA000 + k), 16'h0}) begin
                errors++;
                $display("FAIL restart k=%0d: load=%b addr=%0d start=%b data=%h, want 1 %0d 0",
                         k, bus.fft_load, bus.add_rd, bus.fft_start, bus.wr_data, k);
            end
        end
        @(negedge clk);
        vectors++;
        if (bus.fft_start !== 1'b1) begin
            errors++;
            $display("FAIL restart_start: start=%b, want 1", bus.fft_start);
        end
    endtask

    task automatic test_drop_saturation();
        @(negedge clk);
        bus.sample_valid = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (i == 300) bus.sample_valid = 1'b0;
            vectors++;
            if (bus.overrun !== 1'b1 || bus.drop_cnt !== 8'((i > 255) ? 255 : i)) begin
                errors++;
                $display("FAIL saturate i=%0d: ovr=%b drop=%0d, want 1 %0d",
                         i, bus.overrun, bus.drop_cnt, (i > 255) ? 255 : i);
            end
        end
        @(negedge clk);
        vectors++;
        if (bus.overrun !== 1'b0 || bus.drop_cnt !== 8'd255) begin
            errors++;
            $display("FAIL saturate_end: ovr=%b drop=%0d, want 0 255", bus.overrun, bus.drop_cnt);
        end
        pulse_done();
    endtask

    task automatic test_offset_binary();
        logic [BW-1:0] ins  [3] = '{16'h8000, 16'h0000, 16'h1234};
        logic [BW-1:0] outs [3] = '{16'h0000, 16'h8000, 16'h9234};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_ob.sample_valid = 1'b1;
            bus_ob.sample_in    = ins[i];
            @(negedge clk);
            bus_ob.sample_valid = 1'b0;
            vectors++;
            if (bus_ob.fft_load !== 1'b1 || bus_ob.add_rd !== 9'(i) || bus_ob.wr_data !== {outs[i], 16'h0}) begin
                errors++;
                $display("FAIL offset_bin in=%h: load=%b addr=%0d data=%h, want 1 %0d %h",
                         ins[i], bus_ob.fft_load, bus_ob.add_rd, bus_ob.wr_data, i, {outs[i], 16'h0});
            end
        end
    endtask

    initial begin
        reset               = 1'b1;
        bus.sample_valid    = 1'b0;
        bus.sample_in       = '0;
        bus.fft_done        = 1'b0;
        bus_ob.sample_valid = 1'b0;
        bus_ob.sample_in    = '0;
        bus_ob.fft_done     = 1'b0;

        test_reset();
        test_natural_frame();
        test_drops();
        test_back_to_back();
        test_done_collision_and_reset();
        test_drop_saturation();
        test_offset_binary();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
